vga_fill_apb: RTL and testbench
===============================

# vga_fill_apb

APB initiator that fills an axis-aligned rectangle of the VGA framebuffer with one 24-bit colour, issuing one 32-bit APB write per pixel. Sits between a simple start/done control port, driven by the CPU-side MMIO or a test harness, and the APB fabric in front of the VGA framebuffer slave. It is the requester end of the same APB write path the framebuffer slave answers. It works with any pready/pslverr behaviour, so no zero-wait slave is required.

## Interface
Parameters:
- FB_BASE, 32'h2100_0000, byte address of pixel (0,0)
- H_RES, 640, pixels per row (row stride = H_RES*4 bytes)
- V_RES, 480, rows

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- x0  in  10  left column
- y0  in  10  top row
- w  in  10  width in pixels
- h  in  10  height in rows
- color  in  24  {R,G,B} fill value
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: bad rectangle or pslverr
- out_paddr  out  32  APB address
- out_psel  out  1  APB select
- out_penable  out  1  APB enable
- out_pprot  out  3  constant 3'b000
- out_pwrite  out  1  constant 1
- out_pwdata  out  32  {8'h00, color}
- out_pstrb  out  4  constant 4'hF
- out_pready  in  1  slave ready
- out_prdata  in  32  ignored
- out_pslverr  in  1  slave error, sampled with pready

## Operation
- States: IDLE, LOAD, SETUP, ACCESS, DONE.
- IDLE:
  - On start, latch x0, y0, w, h and color, then go to LOAD.
  - start in any other state is ignored.
- LOAD:
  - Check the rectangle using 11-bit sums.
  - If w==0, h==0, x0+w>H_RES or y0+h>V_RES: go to DONE with err=1 and no APB traffic.
  - Otherwise compute row_addr = FB_BASE + (y0*H_RES + x0)*4, set pix_addr=row_addr, reset col and row counters, and go to SETUP.
- SETUP:
  - psel=1, penable=0, paddr=pix_addr.
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; hold until pready=1.
  - On pready with pslverr=1: abort to DONE with err=1. No further beats.
  - On pready with pslverr=0 and this is the last pixel (col==w-1, row==h-1): go to DONE with err=0.
  - On pready with pslverr=0 and col==w-1 (not last row): row_addr += H_RES*4, pix_addr = new row_addr, col=0, row++, go to SETUP.
  - On pready with pslverr=0 otherwise: pix_addr += 4, col++, go to SETUP.
- DONE: done=1 for one cycle, err valid that cycle, then IDLE.
- Raster order: left to right, then top to bottom.
- pwdata is constant for the whole fill; paddr and pwdata are stable from SETUP through the final ACCESS cycle.
- Address arithmetic is 32-bit modulo.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0, err=0.
  - out_psel=0, out_penable=0, out_paddr=0, out_pwdata=0.
- Reset mid-fill: psel and penable are 0 in the cycle after the reset edge; no done pulse is produced.
- Latency with pready=1 throughout: an N-pixel fill accepted at cycle 0 has LOAD at cycle 1, beats at cycles 2..2N+1 (two cycles each), and done at cycle 2N+2.
- Each wait cycle (pready=0 in ACCESS) adds one cycle.
- Rejected rectangle: done=1, err=1 at cycle 2.
- No idle cycles between beats: SETUP follows ACCESS directly.

## Structure
- Shared package `vga_pkg`:
  - H_RES/V_RES defaults and FB_BASE default.
  - State enum (IDLE, LOAD, SETUP, ACCESS, DONE).
  - APB constant values: PPROT, PSTRB.
- Single module, no sub-module. The y0*H_RES multiply exists only in LOAD and may be a plain multiply.

## Test plan
- 1x1 fill at (0,0), color 24'h123456, pready=1:
  - one beat, paddr 32'h2100_0000, pwdata 32'h0012_3456.
  - SETUP at cycle 2, ACCESS at cycle 3, done=1 and err=0 at cycle 4.
- 2x2 fill at (638,478): paddrs in order 32'h2112_B5F8, 32'h2112_B5FC, 32'h2112_BFF8, 32'h2112_BFFC; done at cycle 10.
- 3x1 fill with pready low for 2 cycles on the second beat:
  - paddr and pwdata hold during the wait.
  - done at cycle 10, err=0.
- Rectangle w=5 at x0=637, and separately h=0: no psel; done=1, err=1 at cycle 2.
- 4x1 fill with pslverr=1 on the second beat: exactly 2 beats issued, then done=1 with err=1.
- reset asserted during ACCESS of a 4x4 fill:
  - psel=0 and busy=0 the next cycle; no done pulse.
  - A new start afterwards fills correctly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA framebuffer APB fill engine.
package vga_pkg;

  localparam int unsigned H_RES_DEF   = 640;
  localparam int unsigned V_RES_DEF   = 480;
  localparam logic [31:0] FB_BASE_DEF = 32'h2100_0000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  localparam logic [2:0] PPROT = 3'b000;
  localparam logic [3:0] PSTRB = 4'hF;

endpackage

// File: rtl/vga_fill_apb.sv
// APB initiator filling a framebuffer rectangle with one colour, one 32-bit
// write per pixel in raster order.
module vga_fill_apb
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE = FB_BASE_DEF,
  parameter int unsigned H_RES   = H_RES_DEF,
  parameter int unsigned V_RES   = V_RES_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  localparam logic [10:0] H_LIM     = H_RES[10:0];
  localparam logic [10:0] V_LIM     = V_RES[10:0];
  localparam logic [31:0] ROW_BYTES = H_RES * 4;

  state_e      state_q, state_d;
  logic [9:0]  x0_q, y0_q, w_q, h_q;
  logic [9:0]  col_q, row_q;
  logic [23:0] color_q;
  logic [31:0] row_addr_q, pix_addr_q;
  logic        err_q;

  logic [10:0] x_end, y_end;
  logic        rect_bad, col_last, row_last;
  logic [31:0] load_addr;
  logic        prdata_unused;

  assign prdata_unused = ^out_prdata;

  // 11-bit sums so x0+w / y0+h cannot wrap before the bound check
  assign x_end     = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end     = {1'b0, y0_q} + {1'b0, h_q};
  assign rect_bad  = (w_q == '0) || (h_q == '0) || (x_end > H_LIM) || (y_end > V_LIM);
  assign load_addr = FB_BASE + ((32'(y0_q) * H_RES + 32'(x0_q)) << 2);
  assign col_last  = (col_q == w_q - 10'd1);
  assign row_last  = (row_q == h_q - 10'd1);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = LOAD;
      LOAD:   state_d = rect_bad ? DONE : SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: if (out_pready) state_d = (out_pslverr || (col_last && row_last)) ? DONE : SETUP;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_addr_q <= '0;
      pix_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            w_q     <= w;
            h_q     <= h;
            color_q <= color;
          end
        end
        LOAD: begin
          err_q      <= rect_bad;
          row_addr_q <= load_addr;
          pix_addr_q <= load_addr;
          col_q      <= '0;
          row_q      <= '0;
        end
        ACCESS: begin
          if (out_pready) begin
            if (out_pslverr) begin
              err_q <= 1'b1;
            end else if (!(col_last && row_last)) begin
              if (col_last) begin
                row_addr_q <= row_addr_q + ROW_BYTES;
                pix_addr_q <= row_addr_q + ROW_BYTES;
                col_q      <= '0;
                row_q      <= row_q + 10'd1;
              end else begin
                pix_addr_q <= pix_addr_q + 32'd4;
                col_q      <= col_q + 10'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    err         = (state_q == DONE) && err_q;
    out_psel    = (state_q == SETUP) || (state_q == ACCESS);
    out_penable = (state_q == ACCESS);
    out_paddr   = pix_addr_q;
    out_pwdata  = {8'h00, color_q};
    out_pprot   = PPROT;
    out_pwrite  = 1'b1;
    out_pstrb   = PSTRB;
  end

endmodule

// File: tb/tb_vga_fill_apb.sv
// Directed bench for vga_fill_apb: APB slave model with stall/error
// injection, beat log, and hand-computed addresses and cycle numbers.
module tb_vga_fill_apb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0, y0 = '0, w = '0, h = '0;
  logic [23:0] color = '0;
  logic        busy, done, err;
  logic [31:0] out_paddr, out_pwdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic        out_pslverr = 1'b0;
  logic [31:0] out_prdata = 32'hDEAD_BEEF;

  vga_fill_apb #(.FB_BASE(32'h2100_0000), .H_RES(640), .V_RES(480)) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
    .busy(busy), .done(done), .err(err),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // written by the stimulus process only
  int cyc0 = 0, stall_beat = -1, stall_len = 0, err_beat = -1;
  // written by the slave/monitor process only
  int beat_idx = 0, waits = 0, done_cnt = 0, done_cyc = 0, hold_bad = 0, psel_cnt = 0;
  logic        done_err = 1'b0;
  logic [31:0] hold_a = '0, hold_d = '0;
  logic [31:0] q_addr[$], q_data[$];
  int          q_setup[$], q_acc[$];

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // APB slave: decides pready/pslverr for the coming edge and logs beats
  always @(negedge clock) begin
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    if (out_psel) psel_cnt++;
    if (out_psel && !out_penable) begin
      hold_a = out_paddr;
      hold_d = out_pwdata;
      q_setup.push_back(cyc - cyc0);
    end
    if (out_psel && out_penable) begin
      if (out_paddr !== hold_a || out_pwdata !== hold_d) hold_bad++;
      if (beat_idx == stall_beat && waits < stall_len) begin
        waits++;
      end else begin
        out_pready  = 1'b1;
        out_pslverr = (beat_idx == err_beat);
        q_addr.push_back(out_paddr);
        q_data.push_back(out_pwdata);
        q_acc.push_back(cyc - cyc0);
        beat_idx++;
        waits = 0;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - cyc0;
      done_err = err;
    end
  end

  task automatic launch(input logic [9:0] fx, fy, fw, fh, input logic [23:0] fc,
                        input int stall_rel, stall_n, err_rel, output int base);
    base = beat_idx;
    @(negedge clock);
    stall_beat = (stall_rel < 0) ? -1 : base + stall_rel;
    stall_len  = stall_n;
    err_beat   = (err_rel < 0) ? -1 : base + err_rel;
    x0 = fx; y0 = fy; w = fw; h = fh; color = fc;
    start = 1'b1;
    cyc0  = cyc;
    @(negedge clock);
    start = 1'b0;
    #1;
  endtask

  task automatic do_fill(input logic [9:0] fx, fy, fw, fh, input logic [23:0] fc,
                         input int stall_rel, stall_n, err_rel, output int base);
    int  prev;
    bit  ok;
    prev = done_cnt;
    launch(fx, fy, fw, fh, fc, stall_rel, stall_n, err_rel, base);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != prev) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    check("done_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    int base, pc, dc;
    bit ok;

    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_psel", 32'(out_psel), 32'd0);
    check("rst_penable", 32'(out_penable), 32'd0);
    check("rst_paddr", out_paddr, 32'h0);
    check("rst_pwdata", out_pwdata, 32'h0);
    check("pprot", 32'(out_pprot), 32'd0);
    check("pwrite", 32'(out_pwrite), 32'd1);
    check("pstrb", 32'(out_pstrb), 32'hF);
    reset = 1'b0;
    @(negedge clock);

    // 1x1 at origin
    do_fill(10'd0, 10'd0, 10'd1, 10'd1, 24'h123456, -1, 0, -1, base);
    check("t1_beats", 32'(beat_idx - base), 32'd1);
    check("t1_paddr", q_addr[base], 32'h2100_0000);
    check("t1_pwdata", q_data[base], 32'h0012_3456);
    check("t1_setup_cyc", 32'(q_setup[base]), 32'd2);
    check("t1_access_cyc", 32'(q_acc[base]), 32'd3);
    check("t1_done_cyc", 32'(done_cyc), 32'd4);
    check("t1_err", 32'(done_err), 32'd0);

    // 2x2 at bottom-right corner, exactly touching both bounds
    do_fill(10'd638, 10'd478, 10'd2, 10'd2, 24'hABCDEF, -1, 0, -1, base);
    check("t2_beats", 32'(beat_idx - base), 32'd4);
    check("t2_a0", q_addr[base], 32'h2112_B5F8);
    check("t2_a1", q_addr[base+1], 32'h2112_B5FC);
    check("t2_a2", q_addr[base+2], 32'h2112_BFF8);
    check("t2_a3", q_addr[base+3], 32'h2112_BFFC);
    check("t2_data", q_data[base+3], 32'h00AB_CDEF);
    check("t2_done_cyc", 32'(done_cyc), 32'd10);
    check("t2_err", 32'(done_err), 32'd0);

    // 3x1 at (10,5) with two wait states on the second beat
    pc = hold_bad;
    do_fill(10'd10, 10'd5, 10'd3, 10'd1, 24'h00FF00, 1, 2, -1, base);
    check("t3_beats", 32'(beat_idx - base), 32'd3);
    check("t3_a0", q_addr[base], 32'h2100_3228);
    check("t3_a1", q_addr[base+1], 32'h2100_322C);
    check("t3_a2", q_addr[base+2], 32'h2100_3230);
    check("t3_stall_acc", 32'(q_acc[base+1]), 32'd7);
    check("t3_hold", 32'(hold_bad - pc), 32'd0);
    check("t3_done_cyc", 32'(done_cyc), 32'd10);
    check("t3_err", 32'(done_err), 32'd0);

    // Rejected: right edge overflow, then zero height
    pc = psel_cnt;
    do_fill(10'd637, 10'd0, 10'd5, 10'd1, 24'h111111, -1, 0, -1, base);
    check("t4a_psel", 32'(psel_cnt - pc), 32'd0);
    check("t4a_done_cyc", 32'(done_cyc), 32'd2);
    check("t4a_err", 32'(done_err), 32'd1);
    pc = psel_cnt;
    do_fill(10'd0, 10'd0, 10'd4, 10'd0, 24'h222222, -1, 0, -1, base);
    check("t4b_psel", 32'(psel_cnt - pc), 32'd0);
    check("t4b_done_cyc", 32'(done_cyc), 32'd2);
    check("t4b_err", 32'(done_err), 32'd1);

    // 4x1 with slave error on second beat
    do_fill(10'd0, 10'd1, 10'd4, 10'd1, 24'h333333, -1, 0, 1, base);
    check("t5_beats", 32'(beat_idx - base), 32'd2);
    check("t5_a1", q_addr[base+1], 32'h2100_0A04);
    check("t5_done_cyc", 32'(done_cyc), 32'd6);
    check("t5_err", 32'(done_err), 32'd1);

    // Reset during ACCESS of a 4x4 fill
    dc = done_cnt;
    launch(10'd0, 10'd0, 10'd4, 10'd4, 24'h444444, -1, 0, -1, base);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((beat_idx - base) >= 2 && out_psel && out_penable) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    check("t6_reach_access", 32'(ok), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("t6_psel", 32'(out_psel), 32'd0);
    check("t6_penable", 32'(out_penable), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("t6_no_done", 32'(done_cnt - dc), 32'd0);
    do_fill(10'd1, 10'd1, 10'd2, 10'd1, 24'h0A0B0C, -1, 0, -1, base);
    check("t6_beats", 32'(beat_idx - base), 32'd2);
    check("t6_a0", q_addr[base], 32'h2100_0A04);
    check("t6_a1", q_addr[base+1], 32'h2100_0A08);
    check("t6_data", q_data[base], 32'h000A_0B0C);
    check("t6_done_cyc", 32'(done_cyc), 32'd6);
    check("t6_err", 32'(done_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
